// File: rtl/io_bus_sequencer_pkg.sv
// Shared definitions for the IO page sequencer: FSM encoding, timeout default,
// read-abort pattern and the device-bit assignments used across the IO map.
package io_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } seq_state_e;

  localparam int          IO_NDEV_DEF    = 16;
  localparam int          IO_TIMEOUT_DEF = 255;
  localparam logic [31:0] IO_RD_ABORT    = 32'hFFFF_FFFF;

  // One-hot word-address bit owned by each device on the IO page.
  localparam int IO_HWCONFIG_BIT  = 0;
  localparam int IO_LEDS_BIT      = 1;
  localparam int IO_UART_DAT_BIT  = 2;
  localparam int IO_UART_CNTL_BIT = 3;
  localparam int IO_SPI_DAT_BIT   = 4;
  localparam int IO_SPI_CNTL_BIT  = 5;

endpackage

// File: rtl/io_bus_sequencer_decode.sv
// One-hot to binary decoder: valid only when exactly one address bit is set.
module io_onehot_decode #(
  parameter int NDEV = 16,
  parameter int IW   = 4
) (
  input  logic [NDEV-1:0] onehot,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic seen;
  logic multi;

  always_comb begin
    seen  = 1'b0;
    multi = 1'b0;
    idx   = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (onehot[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = IW'(i);
      end
    end
    valid = seen & ~multi;
  end

endmodule

// File: rtl/io_bus_sequencer.sv
// IO page sequencer: decodes the one-hot address, strobes one device, waits on
// its busy with a bounded timeout, and returns registered read data.
//
// Handshake: a core strobe is accepted only in IDLE; io_rbusy/io_wbusy high means
// the access is still in flight and no new strobe may be issued until both drop.
module io_bus_sequencer
  import io_bus_sequencer_pkg::*;
#(
  parameter int NDEV    = IO_NDEV_DEF,
  parameter int TIMEOUT = IO_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NDEV-1:0]  io_waddr,
  input  logic             io_rstrb,
  input  logic             io_wstrb,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  output logic             io_rbusy,
  output logic             io_wbusy,
  output logic [NDEV-1:0]  dev_sel,
  output logic             dev_rstrb,
  output logic             dev_wstrb,
  output logic [31:0]      dev_wdata,
  input  logic [NDEV*32-1:0] dev_rdata,
  input  logic [NDEV-1:0]  dev_rbusy,
  input  logic [NDEV-1:0]  dev_wbusy,
  output logic             err_decode,
  output logic             err_timeout,
  input  logic             err_clr,
  output seq_state_e       dbg_state
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  seq_state_e  state, state_next;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] dec_idx;
  logic          dec_valid;
  logic [7:0]    cnt;

  logic load, cnt_inc, rd_done, rd_abort, wr_abort, dec_err, dec_err_rd;
  logic busy_r, busy_w, timeout_hit;
  logic [31:0] rd_mux;

  io_onehot_decode #(.NDEV(NDEV), .IW(IW)) u_decode (
    .onehot (io_waddr),
    .valid  (dec_valid),
    .idx    (dec_idx)
  );

  assign busy_r      = dev_rbusy[sel_idx];
  assign busy_w      = dev_wbusy[sel_idx];
  assign rd_mux      = dev_rdata[{sel_idx, 5'b0} +: 32];
  // Abort on the TIMEOUT-th wait cycle that still sees busy.
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  assign dev_wdata = io_wdata;
  assign io_rbusy  = (state == ST_RD_WAIT);
  assign io_wbusy  = (state == ST_WR_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    dev_sel    = '0;
    dev_rstrb  = 1'b0;
    dev_wstrb  = 1'b0;
    load       = 1'b0;
    cnt_inc    = 1'b0;
    rd_done    = 1'b0;
    rd_abort   = 1'b0;
    wr_abort   = 1'b0;
    dec_err    = 1'b0;
    dec_err_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io_rstrb || io_wstrb) begin
          if (dec_valid) begin
            // A simultaneous read and write is treated as a write only.
            dev_sel    = io_waddr;
            dev_wstrb  = io_wstrb;
            dev_rstrb  = io_rstrb & ~io_wstrb;
            load       = 1'b1;
            state_next = io_wstrb ? ST_WR_WAIT : ST_RD_WAIT;
          end else begin
            dec_err    = 1'b1;
            dec_err_rd = io_rstrb & ~io_wstrb;
          end
        end
      end
      ST_RD_WAIT: begin
        if (!busy_r) begin
          rd_done    = 1'b1;
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          rd_abort   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (!busy_w) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          wr_abort   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_idx     <= '0;
      cnt         <= '0;
      io_rdata    <= '0;
      err_decode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (load) begin
        sel_idx <= dec_idx;
        cnt     <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 8'd1;
      end

      if (rd_done)         io_rdata <= rd_mux;
      else if (rd_abort)   io_rdata <= IO_RD_ABORT;
      else if (dec_err_rd) io_rdata <= '0;

      if (err_clr) begin
        err_decode  <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (dec_err)              err_decode  <= 1'b1;
        if (rd_abort || wr_abort) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Directed bench for io_bus_sequencer: reads, writes, decode errors, timeout,
// dual strobes and asynchronous reset mid-access.
module tb_io_bus_sequencer;
  import io_bus_sequencer_pkg::*;

  localparam int NDEV = 16;

  logic              clk;
  logic              resetn;
  logic [NDEV-1:0]   io_waddr;
  logic              io_rstrb;
  logic              io_wstrb;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_rbusy;
  logic              io_wbusy;
  logic [NDEV-1:0]   dev_sel;
  logic              dev_rstrb;
  logic              dev_wstrb;
  logic [31:0]       dev_wdata;
  logic [NDEV*32-1:0] dev_rdata;
  logic [NDEV-1:0]   dev_rbusy;
  logic [NDEV-1:0]   dev_wbusy;
  logic              err_decode;
  logic              err_timeout;
  logic              err_clr;
  seq_state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  io_bus_sequencer #(.NDEV(NDEV), .TIMEOUT(255)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .io_waddr    (io_waddr),
    .io_rstrb    (io_rstrb),
    .io_wstrb    (io_wstrb),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_rbusy    (io_rbusy),
    .io_wbusy    (io_wbusy),
    .dev_sel     (dev_sel),
    .dev_rstrb   (dev_rstrb),
    .dev_wstrb   (dev_wstrb),
    .dev_wdata   (dev_wdata),
    .dev_rdata   (dev_rdata),
    .dev_rbusy   (dev_rbusy),
    .dev_wbusy   (dev_wbusy),
    .err_decode  (err_decode),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NDEV-1:0] a, input logic r, input logic w);
    io_waddr = a;
    io_rstrb = r;
    io_wstrb = w;
  endtask

  int n;
  int wstrb_cnt;

  initial begin
    resetn    = 1'b0;
    io_waddr  = '0;
    io_rstrb  = 1'b0;
    io_wstrb  = 1'b0;
    io_wdata  = '0;
    dev_rbusy = '0;
    dev_wbusy = '0;
    err_clr   = 1'b0;
    for (int i = 0; i < NDEV; i++)
      dev_rdata[32*i +: 32] = {16'hA5A5, i[7:0], i[7:0]};

    tick();
    tick();
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_rbusy", {31'b0, io_rbusy}, 32'h0);
    chk("rst_wbusy", {31'b0, io_wbusy}, 32'h0);
    chk("rst_errs", {30'b0, err_decode, err_timeout}, 32'h0);
    chk("rst_sel", {16'b0, dev_sel}, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;
    tick();

    // Read device 3, never busy.
    drive(16'h0008, 1'b1, 1'b0);
    #1;
    chk("rd3_sel", {16'b0, dev_sel}, 32'h0000_0008);
    chk("rd3_rstrb", {30'b0, dev_rstrb, dev_wstrb}, 32'h2);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    #1;
    chk("rd3_rbusy_t1", {31'b0, io_rbusy}, 32'h1);
    chk("rd3_nostrb_t1", {15'b0, dev_rstrb, dev_sel}, 32'h0);
    tick();
    chk("rd3_rbusy_t2", {31'b0, io_rbusy}, 32'h0);
    chk("rd3_rdata", io_rdata, 32'hA5A5_0303);

    // Write device 0, busy for 4 cycles after the strobe.
    io_wdata = 32'hCAFE_F00D;
    drive(16'h0001, 1'b0, 1'b1);
    #1;
    chk("wr0_sel", {16'b0, dev_sel}, 32'h0000_0001);
    chk("wr0_wdata", dev_wdata, 32'hCAFE_F00D);
    wstrb_cnt = dev_wstrb ? 1 : 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      drive(16'h0000, 1'b0, 1'b0);
      dev_wbusy[0] = (k <= 4);
      #1;
      if (dev_wstrb) wstrb_cnt++;
      chk($sformatf("wr0_wbusy_t%0d", k), {31'b0, io_wbusy}, {31'b0, (k <= 5)});
    end
    chk("wr0_wstrb_once", 32'(wstrb_cnt), 32'd1);
    chk("wr0_rdata_kept", io_rdata, 32'hA5A5_0303);

    // Decode errors: zero-hot then multi-hot.
    drive(16'h0000, 1'b1, 1'b0);
    #1;
    chk("dec0_nostrb", {15'b0, dev_rstrb, dev_sel}, 32'h0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    chk("dec0_rbusy", {31'b0, io_rbusy}, 32'h0);
    chk("dec0_rdata", io_rdata, 32'h0);
    chk("dec0_err", {31'b0, err_decode}, 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("dec0_clr", {31'b0, err_decode}, 32'h0);
    // Reload io_rdata with nonzero data before the multi-hot read.
    drive(16'h0080, 1'b1, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    tick();
    chk("rd7_rdata", io_rdata, 32'hA5A5_0707);
    drive(16'h0011, 1'b1, 1'b0);
    #1;
    chk("dec11_nostrb", {15'b0, dev_rstrb, dev_sel}, 32'h0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    chk("dec11_rbusy", {31'b0, io_rbusy}, 32'h0);
    chk("dec11_rdata", io_rdata, 32'h0);
    chk("dec11_err", {31'b0, err_decode}, 32'h1);
    err_clr = 1'b1;
    tick();
    // Clear wins over a same-cycle decode error.
    drive(16'h0000, 1'b0, 1'b1);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("dec_clr_prio", {31'b0, err_decode}, 32'h0);

    // Read device 5 with busy stuck: abort after 255 wait cycles.
    dev_rbusy[5] = 1'b1;
    drive(16'h0020, 1'b1, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    n = 0;
    while (io_rbusy && n < 400) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", 32'(n), 32'd255);
    chk("to_rdata", io_rdata, 32'hFFFF_FFFF);
    chk("to_err", {31'b0, err_timeout}, 32'h1);
    chk("to_state", 32'(dbg_state), 32'(ST_IDLE));
    dev_rbusy[5] = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", {30'b0, err_timeout, err_decode}, 32'h0);

    // Read and write together on device 2: write wins.
    drive(16'h0004, 1'b1, 1'b1);
    #1;
    chk("rw2_strobes", {14'b0, dev_rstrb, dev_wstrb, dev_sel}, 32'h0001_0004);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    chk("rw2_busy_t1", {30'b0, io_rbusy, io_wbusy}, 32'h1);
    tick();
    chk("rw2_busy_t2", {30'b0, io_rbusy, io_wbusy}, 32'h0);
    chk("rw2_rdata", io_rdata, 32'hFFFF_FFFF);
    chk("rw2_noerr", {30'b0, err_decode, err_timeout}, 32'h0);

    // Asynchronous reset during RD_WAIT on device 9.
    dev_rbusy[9] = 1'b1;
    drive(16'h0200, 1'b1, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    tick();
    chk("ar_rbusy_before", {31'b0, io_rbusy}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_rbusy", {31'b0, io_rbusy}, 32'h0);
    chk("ar_rdata", io_rdata, 32'h0);
    chk("ar_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ar_nostrb", {15'b0, dev_rstrb, dev_sel}, 32'h0);
    tick();
    resetn = 1'b1;
    dev_rbusy[9] = 1'b0;
    tick();
    drive(16'h0200, 1'b1, 1'b0);
    tick();
    drive(16'h0000, 1'b0, 1'b0);
    chk("ar_rd9_rbusy", {31'b0, io_rbusy}, 32'h1);
    tick();
    chk("ar_rd9_rdata", io_rdata, 32'hA5A5_0909);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
